// File: rtl/alphabet_sweep_ctrl.sv
// Sequencer for the Alphabet_Gen lookup: sweeps (D,S) or performs a single
// lookup, presenting each captured code over a valid/ready handshake.
module alphabet_sweep_ctrl #(
  parameter int D_MIN = 1,
  parameter int D_MAX = 13,
  parameter int S_MAX = 5,
  parameter int DW    = 6,
  parameter int SW    = 3,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          single,
  input  logic [DW-1:0] d_in,
  input  logic [SW-1:0] s_in,
  output logic [DW-1:0] gen_d,
  output logic [SW-1:0] gen_s,
  input  logic [AW-1:0] gen_alpha,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_d,
  output logic [SW-1:0] out_s,
  output logic [AW-1:0] out_alpha,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [7:0]    zero_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, PRESENT, DONE} state_t;

  state_t state, state_nxt;
  logic   mode_single;
  logic   at_end;

  assign at_end = mode_single || (gen_d == DW'(D_MAX) && gen_s == SW'(S_MAX));
  assign busy   = (state == DRIVE) || (state == PRESENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = out_last ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_single <= 1'b0;
      gen_d       <= '0;
      gen_s       <= '0;
      out_valid   <= 1'b0;
      out_d       <= '0;
      out_s       <= '0;
      out_alpha   <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      zero_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_single <= single;
          gen_d       <= single ? d_in : DW'(D_MIN);
          gen_s       <= single ? s_in : '0;
          zero_cnt    <= '0;
        end
        DRIVE: begin
          out_alpha <= gen_alpha;
          out_d     <= gen_d;
          out_s     <= gen_s;
          out_valid <= 1'b1;
          out_last  <= at_end;
          if (gen_alpha == '0 && zero_cnt != 8'hFF) zero_cnt <= zero_cnt + 8'd1;
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          // Advance only when more points remain; the final point keeps its D/S.
          if (!out_last) begin
            if (gen_s == SW'(S_MAX)) begin
              gen_s <= '0;
              gen_d <= gen_d + DW'(1);
            end else begin
              gen_s <= gen_s + SW'(1);
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          out_last <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alphabet_sweep_ctrl.sv
// Directed bench for alphabet_sweep_ctrl with a behavioural generator table.
module tb_alphabet_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, single, out_ready;
  logic [5:0] d_in, gen_d, out_d;
  logic [2:0] s_in, gen_s, out_s;
  logic [4:0] gen_alpha, out_alpha;
  logic       out_valid, out_last, busy, done;
  logic [7:0] zero_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Generator stand-in: known spot codes, nonzero elsewhere in range, 0 outside.
  function automatic logic [4:0] gen_model(input logic [5:0] d, input logic [2:0] s);
    int v;
    if (d < 6'd1 || d > 6'd13 || s > 3'd5) return 5'd0;
    case ({d, s})
      {6'd1, 3'd0}:  return 5'd1;
      {6'd7, 3'd3}:  return 5'd6;
      {6'd7, 3'd5}:  return 5'd6;
      {6'd8, 3'd0}:  return 5'd7;
      {6'd8, 3'd1}:  return 5'd8;
      {6'd11, 3'd0}: return 5'd9;
      {6'd13, 3'd5}: return 5'd10;
      default: begin
        v = (int'(d) * 7 + int'(s) * 3) % 30 + 1;
        return 5'(v);
      end
    endcase
  endfunction

  assign gen_alpha = gen_model(gen_d, gen_s);

  alphabet_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single),
    .d_in(d_in), .s_in(s_in), .gen_d(gen_d), .gen_s(gen_s),
    .gen_alpha(gen_alpha), .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_s(out_s), .out_alpha(out_alpha), .out_last(out_last),
    .busy(busy), .done(done), .zero_cnt(zero_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gen_d"}, 32'(gen_d), 0);
    chk({tag, " gen_s"}, 32'(gen_s), 0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_d"}, 32'(out_d), 0);
    chk({tag, " out_s"}, 32'(out_s), 0);
    chk({tag, " out_alpha"}, 32'(out_alpha), 0);
    chk({tag, " out_last"}, 32'(out_last), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " zero_cnt"}, 32'(zero_cnt), 0);
  endtask

  task automatic do_start(input logic sgl, input logic [5:0] d, input logic [2:0] s);
    single = sgl; d_in = d; s_in = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sweep with ready always high; checks order, codes, last flag and done timing.
  task automatic sweep_full(input string tag);
    int idx = 0;
    int cyc = 0;
    bit seen_done = 0;
    out_ready = 1'b1;
    do_start(1'b0, 6'd0, 3'd0);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      if (out_valid) begin
        chk({tag, " d"}, 32'(out_d), 32'(1 + idx / 6));
        chk({tag, " s"}, 32'(out_s), 32'(idx % 6));
        chk({tag, " alpha"}, 32'(out_alpha), 32'(gen_model(6'(1 + idx / 6), 3'(idx % 6))));
        chk({tag, " last"}, 32'(out_last), 32'(idx == 77));
        idx++;
      end
      if (done) begin
        seen_done = 1;
        chk({tag, " done cycle"}, cyc, 157);
      end else begin
        step();
        cyc++;
      end
    end
    chk({tag, " done seen"}, 32'(seen_done), 1);
    chk({tag, " points"}, idx, 78);
    chk({tag, " zero_cnt"}, 32'(zero_cnt), 0);
    step();
    chk({tag, " done pulse width"}, 32'(done), 0);
  endtask

  initial begin
    int  idx, cyc;
    bit  prev_valid, fin;
    logic [5:0] pd;
    logic [2:0] ps;
    logic [4:0] pa;

    rst_n = 1'b0; start = 1'b0; single = 1'b0; d_in = '0; s_in = '0; out_ready = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single lookup (7,3) with consumer stalling one cycle
    do_start(1'b1, 6'd7, 3'd3);
    chk("single busy", 32'(busy), 1);
    chk("single gen_d", 32'(gen_d), 7);
    chk("single gen_s", 32'(gen_s), 3);
    chk("single early valid", 32'(out_valid), 0);
    step();
    chk("single valid", 32'(out_valid), 1);
    chk("single alpha", 32'(out_alpha), 6);
    chk("single out_d", 32'(out_d), 7);
    chk("single out_s", 32'(out_s), 3);
    chk("single last", 32'(out_last), 1);
    step();
    chk("single stall valid", 32'(out_valid), 1);
    chk("single stall alpha", 32'(out_alpha), 6);
    out_ready = 1'b1;
    step();
    chk("single after hs valid", 32'(out_valid), 0);
    chk("single after hs busy", 32'(busy), 0);
    chk("single after hs done", 32'(done), 0);
    step();
    chk("single done", 32'(done), 1);
    chk("single zero_cnt", 32'(zero_cnt), 0);
    step();
    chk("single done cleared", 32'(done), 0);
    chk("single last cleared", 32'(out_last), 0);

    // Single lookup of an unmapped point
    do_start(1'b1, 6'd14, 3'd0);
    step();
    chk("unmapped alpha", 32'(out_alpha), 0);
    chk("unmapped valid", 32'(out_valid), 1);
    step(); step();
    chk("unmapped done", 32'(done), 1);
    chk("unmapped zero_cnt", 32'(zero_cnt), 1);
    step();
    chk("zero_cnt holds", 32'(zero_cnt), 1);

    sweep_full("sweep");

    // Random stalls plus stray start pulses while busy
    out_ready = 1'b0;
    do_start(1'b0, 6'd0, 3'd0);
    idx = 0; prev_valid = 0; fin = 0; pd = '0; ps = '0; pa = '0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      if (out_valid) begin
        chk("stall d", 32'(out_d), 32'(1 + idx / 6));
        chk("stall s", 32'(out_s), 32'(idx % 6));
        chk("stall alpha", 32'(out_alpha), 32'(gen_model(6'(1 + idx / 6), 3'(idx % 6))));
        if (prev_valid) begin
          chk("stall hold d", 32'(out_d), 32'(pd));
          chk("stall hold s", 32'(out_s), 32'(ps));
          chk("stall hold alpha", 32'(out_alpha), 32'(pa));
        end
      end
      if (done) fin = 1;
      else begin
        pd = out_d; ps = out_s; pa = out_a_hold(out_alpha);
        out_ready = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 3) == 0);
        single = 1'b1; d_in = 6'd3; s_in = 3'd2;
        prev_valid = out_valid && !out_ready;
        if (out_valid && out_ready) idx++;
        step();
        start = 1'b0;
      end
    end
    chk("stall done seen", 32'(fin), 1);
    chk("stall points", idx, 78);
    step();
    chk("stall stays idle", 32'(busy), 0);

    // Reset while presenting (5,2)
    out_ready = 1'b1;
    do_start(1'b0, 6'd0, 3'd0);
    cyc = 0;
    while (!(out_valid && out_d == 6'd5 && out_s == 3'd2) && cyc < 400) begin
      step();
      cyc++;
    end
    chk("reach (5,2)", 32'(cyc < 400), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid reset");
    step();
    rst_n = 1'b1;
    step();
    chk("post reset idle", 32'(busy), 0);
    do_start(1'b0, 6'd0, 3'd0);
    step();
    chk("fresh sweep d", 32'(out_d), 1);
    chk("fresh sweep s", 32'(out_s), 0);
    chk("fresh sweep alpha", 32'(out_alpha), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  function automatic logic [4:0] out_a_hold(input logic [4:0] a);
    return a;
  endfunction

endmodule
